// File: rtl/pdp8_clk_enable_if.sv
// Front-panel control and CPU enable bundle for the PDP-8 clock-enable generator.
interface pdp8_clk_enable_if #(
  parameter int SEL_W     = 4,
  parameter int CNT_OUT_W = 16
);
  logic [SEL_W-1:0]     rate_sel;
  logic [1:0]           mode;
  logic                 step;
  logic [7:0]           burst_len;
  logic                 ce;
  logic                 busy;
  logic [CNT_OUT_W-1:0] ce_count;

  modport master (output rate_sel, mode, step, burst_len,
                  input  ce, busy, ce_count);
  modport slave  (input  rate_sel, mode, step, burst_len,
                  output ce, busy, ce_count);
endinterface

// File: rtl/pdp8_clk_enable.sv
// CPU clock-enable generator: power-of-two rate, halt, single-step and counted
// burst modes, all producing a registered one-cycle ce on the system clock.
module pdp8_clk_enable #(
  parameter int CNT_W       = 25,
  parameter int SEL_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_OUT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  pdp8_clk_enable_if.slave   bus
);
  localparam logic [2:0] S_HALT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_BIDLE = 3'd3;
  localparam logic [2:0] S_BACT  = 3'd4;
  localparam int unsigned MAX_SH = CNT_W - 1;

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, period_m1;
  logic [8:0]             rem_q, rem_d;
  logic                   ce_q, ce_d, busy_q, busy_d;
  logic [CNT_OUT_W-1:0]   ce_count_q;
  logic [SEL_W-1:0]       rate_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, rise_q;
  logic [1:0]             cls, entry_mode;
  logic [2:0]             entry_state;
  logic                   rate_chg;

  always_comb begin
    if (32'(bus.rate_sel) >= MAX_SH)
      period_m1 = {1'b0, {(CNT_W-1){1'b1}}};
    else
      period_m1 = (CNT_W'(1) << bus.rate_sel) - CNT_W'(1);
  end

  always_comb begin
    case (state_q)
      S_RUN:   cls = 2'b00;
      S_HALT:  cls = 2'b01;
      S_STEP:  cls = 2'b10;
      default: cls = 2'b11;
    endcase
    entry_mode = bus.mode;
    case (entry_mode)
      2'b00:   entry_state = S_RUN;
      2'b01:   entry_state = S_HALT;
      2'b10:   entry_state = S_STEP;
      default: entry_state = S_BIDLE;
    endcase
  end

  assign rate_chg = (bus.rate_sel != rate_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ce_d    = 1'b0;
    busy_d  = busy_q;
    if (bus.mode != cls) begin
      // Mode change wins over everything, including a coincident step edge.
      state_d = entry_state;
      cnt_d   = period_m1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (rate_chg) cnt_d = period_m1;
          else if (cnt_q == '0) begin
            ce_d  = 1'b1;
            cnt_d = period_m1;
          end else cnt_d = cnt_q - CNT_W'(1);
        end
        S_HALT: cnt_d = period_m1;
        S_STEP: begin
          cnt_d = period_m1;
          ce_d  = rise_q;
        end
        S_BIDLE: begin
          cnt_d = period_m1;
          if (rise_q) begin
            rem_d   = (bus.burst_len == 8'd0) ? 9'd256 : {1'b0, bus.burst_len};
            busy_d  = 1'b1;
            state_d = S_BACT;
          end
        end
        S_BACT: begin
          if (rem_q == '0) begin
            state_d = S_BIDLE;
            busy_d  = 1'b0;
            cnt_d   = period_m1;
          end else if (rate_chg) cnt_d = period_m1;
          else if (cnt_q == '0) begin
            ce_d  = 1'b1;
            rem_d = rem_q - 9'd1;
            cnt_d = period_m1;
          end else cnt_d = cnt_q - CNT_W'(1);
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_HALT;
      cnt_q      <= '0;
      rem_q      <= '0;
      ce_q       <= 1'b0;
      busy_q     <= 1'b0;
      ce_count_q <= '0;
      rate_q     <= '0;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
      ce_count_q <= ce_count_q + {{(CNT_OUT_W-1){1'b0}}, ce_q};
      rate_q     <= bus.rate_sel;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.step};
      prev_q     <= sync_q[SYNC_STAGES-1];
      rise_q     <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign bus.ce       = ce_q;
  assign bus.busy     = busy_q;
  assign bus.ce_count = ce_count_q;
endmodule

// File: tb/tb_pdp8_clk_enable.sv
// Bench for pdp8_clk_enable: directed mode/rate/step sequences and a random
// phase, all checked each cycle against a pulse-schedule model.
module tb_pdp8_clk_enable;
  localparam int CNT_W_A = 25;
  localparam int SYNC    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pdp8_clk_enable_if #(.SEL_W(4), .CNT_OUT_W(16)) bus_a ();
  pdp8_clk_enable_if #(.SEL_W(4), .CNT_OUT_W(4))  bus_b ();

  pdp8_clk_enable #(.CNT_W(CNT_W_A), .SEL_W(4), .SYNC_STAGES(SYNC), .CNT_OUT_W(16))
    u_a (.clk(clk), .reset(reset), .bus(bus_a));
  pdp8_clk_enable #(.CNT_W(4), .SEL_W(4), .SYNC_STAGES(SYNC), .CNT_OUT_W(4))
    u_b (.clk(clk), .reset(reset), .bus(bus_b));

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Model: absolute edge numbers for the next periodic pulse and step triggers.
  longint     e = 0;
  longint     next_ce = 0;
  longint     pend[$];
  int         mcls;
  bit         prev_st, burst, exp_ce, exp_busy;
  int         rem;
  logic [3:0] rprev;
  logic [15:0] exp_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mcls = 1; prev_st = 0; burst = 0; exp_ce = 0; exp_busy = 0;
    rem = 0; rprev = '0; exp_count = '0;
    pend.delete();
  endtask

  task automatic model_edge(input logic [1:0] m, input logic [3:0] r,
                            input logic st, input logic [7:0] bl);
    longint p;
    bit trig;
    e++;
    trig = 0;
    if (pend.size() > 0 && pend[0] == e) begin
      trig = 1;
      void'(pend.pop_front());
    end
    if (st && !prev_st) pend.push_back(e + SYNC + 1);
    prev_st = st;
    exp_count = exp_count + 16'(exp_ce);
    exp_ce = 0;
    p = longint'(1) << ((int'(r) >= CNT_W_A - 1) ? CNT_W_A - 1 : int'(r));
    if (int'(m) != mcls) begin
      mcls = int'(m); exp_busy = 0; burst = 0; next_ce = e + p;
    end else if (mcls == 0) begin
      if (r != rprev) next_ce = e + p;
      else if (e == next_ce) begin exp_ce = 1; next_ce = e + p; end
    end else if (mcls == 2) begin
      exp_ce = trig;
    end else if (mcls == 3) begin
      if (burst) begin
        if (rem == 0) begin burst = 0; exp_busy = 0; end
        else if (r != rprev) next_ce = e + p;
        else if (e == next_ce) begin exp_ce = 1; rem--; next_ce = e + p; end
      end else if (trig) begin
        burst = 1; exp_busy = 1; rem = (bl == 8'd0) ? 256 : int'(bl); next_ce = e + p;
      end
    end
    rprev = r;
  endtask

  task automatic tick();
    model_edge(bus_a.mode, bus_a.rate_sel, bus_a.step, bus_a.burst_len);
    @(posedge clk); #1;
    chk("ce", 32'(bus_a.ce), 32'(exp_ce));
    chk("busy", 32'(bus_a.busy), 32'(exp_busy));
    chk("ce_count", 32'(bus_a.ce_count), 32'(exp_count));
    if (bus_a.ce) pulses++;
  endtask

  initial begin
    logic [3:0] expb;
    bus_a.mode = 2'b00; bus_a.rate_sel = 4'd0; bus_a.step = 1'b0; bus_a.burst_len = 8'd0;
    bus_b.mode = 2'b00; bus_b.rate_sel = 4'd0; bus_b.step = 1'b0; bus_b.burst_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", 32'(bus_a.ce), 32'd0);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    chk("rst_count", 32'(bus_a.ce_count), 32'd0);
    chk("rst_count_b", 32'(bus_b.ce_count), 32'd0);
    model_reset();
    reset = 1'b0;

    // Period 1 from release; narrow counter on instance b wraps F->0 and ends at 1.
    for (int i = 1; i <= 19; i++) begin
      tick();
      expb = (i >= 2) ? 4'(i - 2) : 4'd0;
      chk("b_ce", 32'(bus_b.ce), (i >= 2) ? 32'd1 : 32'd0);
      chk("b_count", 32'(bus_b.ce_count), 32'(expb));
      if (i == 12) chk("count_after_10", 32'(bus_a.ce_count), 32'd10);
    end

    // Saturated period on instance b: rate 9 clamps to 2^(4-1) = 8.
    bus_b.rate_sel = 4'd9;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("b_sat_ce", 32'(bus_b.ce), (i == 9 || i == 17) ? 32'd1 : 32'd0);
    end
    bus_b.mode = 2'b01;

    // Rate 3, then rate 1 mid-period.
    bus_a.rate_sel = 4'd3;
    repeat (29) tick();
    bus_a.rate_sel = 4'd1;
    pulses = 0;
    repeat (10) tick();
    chk("rate1_pulses", 32'(pulses), 32'd4);

    // Single-step: hold high, release, press again.
    bus_a.mode = 2'b10;
    repeat (5) tick();
    pulses = 0;
    bus_a.step = 1'b1; repeat (50) tick();
    bus_a.step = 1'b0; repeat (10) tick();
    bus_a.step = 1'b1; repeat (20) tick();
    bus_a.step = 1'b0; repeat (5) tick();
    chk("step_pulses", 32'(pulses), 32'd2);

    // Burst of 5 at period 4, with an ignored press mid-burst.
    bus_a.mode = 2'b11; bus_a.rate_sel = 4'd2; bus_a.burst_len = 8'd5;
    repeat (3) tick();
    pulses = 0;
    bus_a.step = 1'b1; repeat (3) tick();
    bus_a.step = 1'b0; repeat (10) tick();
    bus_a.step = 1'b1; repeat (2) tick();
    bus_a.step = 1'b0; repeat (30) tick();
    chk("burst5_pulses", 32'(pulses), 32'd5);

    // burst_len 0 means 256.
    bus_a.burst_len = 8'd0; bus_a.rate_sel = 4'd0;
    repeat (3) tick();
    pulses = 0;
    bus_a.step = 1'b1; repeat (2) tick();
    bus_a.step = 1'b0; repeat (275) tick();
    chk("burst256_pulses", 32'(pulses), 32'd256);

    // Abort mid-burst by switching to halt.
    bus_a.burst_len = 8'd20; bus_a.rate_sel = 4'd1;
    bus_a.step = 1'b1; repeat (2) tick();
    bus_a.step = 1'b0; repeat (13) tick();
    chk("busy_mid_burst", 32'(bus_a.busy), 32'd1);
    bus_a.mode = 2'b01;
    tick();
    chk("busy_after_abort", 32'(bus_a.busy), 32'd0);
    pulses = 0;
    repeat (10) tick();
    chk("abort_pulses", 32'(pulses), 32'd0);

    // Async reset between edges while running at period 1.
    bus_a.mode = 2'b00; bus_a.rate_sel = 4'd0;
    repeat (6) tick();
    chk("pre_reset_ce", 32'(bus_a.ce), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ce", 32'(bus_a.ce), 32'd0);
    chk("async_rst_busy", 32'(bus_a.busy), 32'd0);
    chk("async_rst_count", 32'(bus_a.ce_count), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus_a.rate_sel = 4'd2;
    repeat (12) tick();

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) bus_a.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) bus_a.rate_sel = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) bus_a.step = ~bus_a.step;
      if ($urandom_range(0, 99) == 0) bus_a.burst_len = 8'($urandom_range(0, 6));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
